// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings used by both the ALU and its
// execute-stage controller, plus the controller's 2-bit FSM state encoding.
package alu_pkg;

  localparam logic [3:0] OC_ADD = 4'd0;
  localparam logic [3:0] OC_SUB = 4'd1;
  localparam logic [3:0] OC_MUL = 4'd2;
  localparam logic [3:0] OC_DIV = 4'd3;
  localparam logic [3:0] OC_NOT = 4'd4;
  localparam logic [3:0] OC_XOR = 4'd5;
  localparam logic [3:0] OC_OR  = 4'd6;
  localparam logic [3:0] OC_AND = 4'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/alu_exec_ctrl.sv
// Execute-stage controller in front of the combinational ALU: captures an op,
// registers the ALU result with zero/error flags and hands it to writeback.
// Optional macro ALU_ACC_FWD_EN: in_use_acc selects the last result as operand a.
module alu_exec_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_oc,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic                  in_use_acc,
  output logic [3:0]            alu_oc,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  input  logic [DATA_WIDTH-1:0] alu_f,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic                  out_zero,
  output logic                  out_err,
  output logic [CNT_WIDTH-1:0]  op_count
);

  logic [1:0]            r_state;
  logic [3:0]            r_oc;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_zero;
  logic                  r_err;
  logic [CNT_WIDTH-1:0]  r_count;

  logic                  w_accept;
  logic                  w_release;
  logic [DATA_WIDTH-1:0] w_opa;
  logic [DATA_WIDTH-1:0] w_result;
  logic                  w_err;

  assign w_accept  = (r_state == ST_IDLE) && in_valid;
  assign w_release = (r_state == ST_DONE) && out_ready;

`ifdef ALU_ACC_FWD_EN
  assign w_opa = in_use_acc ? r_result : in_a;
`else
  logic w_unused;
  assign w_unused = in_use_acc;
  assign w_opa    = in_a;
`endif

  // Guard cases the ALU cannot handle: illegal opcodes and divide by zero.
  always_comb begin
    w_result = {DATA_WIDTH{1'b0}};
    w_err    = 1'b0;
    if (r_oc[3]) begin
      w_result = {DATA_WIDTH{1'b0}};
      w_err    = 1'b1;
    end else if ((r_oc == OC_DIV) && (r_b == {DATA_WIDTH{1'b0}})) begin
      w_result = {DATA_WIDTH{1'b1}};
      w_err    = 1'b1;
    end else begin
      w_result = alu_f;
      w_err    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: r_state <= w_accept ? ST_EXEC : ST_IDLE;
        ST_EXEC: r_state <= ST_DONE;
        ST_DONE: r_state <= w_release ? ST_IDLE : ST_DONE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_oc <= 4'd0;
      r_a  <= {DATA_WIDTH{1'b0}};
      r_b  <= {DATA_WIDTH{1'b0}};
    end else if (w_accept) begin
      r_oc <= in_oc;
      r_a  <= w_opa;
      r_b  <= in_b;
    end
  end

  // Result and flags load once, at the end of EXEC, and hold through DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= {DATA_WIDTH{1'b0}};
      r_zero   <= 1'b0;
      r_err    <= 1'b0;
    end else if (r_state == ST_EXEC) begin
      r_result <= w_result;
      r_zero   <= (w_result == {DATA_WIDTH{1'b0}});
      r_err    <= w_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= {CNT_WIDTH{1'b0}};
    end else if (w_release) begin
      r_count <= r_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign in_ready   = (r_state == ST_IDLE);
  assign out_valid  = (r_state == ST_DONE);
  assign alu_oc     = r_oc;
  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign out_result = r_result;
  assign out_zero   = r_zero;
  assign out_err    = r_err;
  assign op_count   = r_count;

endmodule
